// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int WAIT_CNT_W = 4;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline-side data port of the responder: request, response and stats.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              hold;
    logic              resp_valid;
    logic              err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, hold, resp_valid, err, rd_count, wr_count, stall_count
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, hold, resp_valid, err, rd_count, wr_count, stall_count
    );
endinterface

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read, clears on reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            // rd_zero returns 0 for out-of-range reads without touching the array
            if (re) begin
                rdata <= rd_zero ? '0 : mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with pipeline hold.
// Optional access/stall counters enabled by defining DMEM_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; hold follows the request
//   WAIT  | access latched, counting down wait states, hold=1
//   RESP  | one-cycle completion: resp_valid (and err) high, hold=0
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    // WAIT lasts LATENCY-1 cycles; leaving at terminal count 0 means loading LATENCY-2
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    op_wr;
    logic                    op_err;
    logic                    op_oor;
    logic [ADDR_W-1:0]       op_addr;
    logic [DATA_W-1:0]       op_data;
    logic                    resp_valid_q;
    logic                    err_q;

    logic                    req;
    logic                    req_oor;
    logic                    req_err;
    logic                    commit;
    logic                    commit_wr;
    logic                    commit_oor;
    logic [ADDR_W-1:0]       commit_addr;
    logic [DATA_W-1:0]       commit_data;
    logic [DATA_W-1:0]       rdata;

    assign req     = bus.mem_read | bus.mem_write;
    assign req_oor = |bus.addr[31:ADDR_W];
    assign req_err = (bus.mem_read & bus.mem_write) | req_oor;

    // With LATENCY=1 the access commits on the accepting edge, straight from the inputs
    always_comb begin
        commit      = 1'b0;
        commit_wr   = op_wr;
        commit_oor  = op_oor;
        commit_addr = op_addr;
        commit_data = op_data;
        if (state == WAIT && wait_cnt == '0) begin
            commit = 1'b1;
        end else if (LATENCY == 1 && state == IDLE && req) begin
            commit      = 1'b1;
            commit_wr   = bus.mem_write;
            commit_oor  = req_oor;
            commit_addr = bus.addr[ADDR_W-1:0];
            commit_data = bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            op_wr        <= 1'b0;
            op_err       <= 1'b0;
            op_oor       <= 1'b0;
            op_addr      <= '0;
            op_data      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr   <= bus.mem_write;
                        op_err  <= req_err;
                        op_oor  <= req_oor;
                        op_addr <= bus.addr[ADDR_W-1:0];
                        op_data <= bus.write_data;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= req_err;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= op_err;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (commit & commit_wr & ~commit_oor),
        .re      (commit & ~commit_wr),
        .rd_zero (commit_oor),
        .addr    (commit_addr),
        .wdata   (commit_data),
        .rdata   (rdata)
    );

    assign bus.hold       = (state == WAIT) | ((state == IDLE) & req);
    assign bus.resp_valid = resp_valid_q;
    assign bus.err        = err_q;
    assign bus.read_data  = rdata;

`ifdef DMEM_STATS_EN
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (commit && !commit_wr) rd_cnt <= sat_inc(rd_cnt);
            if (commit && commit_wr)  wr_cnt <= sat_inc(wr_cnt);
            if (bus.hold)             stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.rd_count    = rd_cnt;
    assign bus.wr_count    = wr_cnt;
    assign bus.stall_count = stall_cnt;
`else
    assign bus.rd_count    = '0;
    assign bus.wr_count    = '0;
    assign bus.stall_count = '0;
`endif

endmodule
